butterfly_unit: RTL and testbench
=================================

Name: butterfly_unit

Overview:
- Radix-2 decimation-in-time butterfly for the FFT datapath, instantiated eight per FFT stage by the stage controller.
- Takes complex A, B and twiddle W, and produces A+W·B and A−W·B.
- Complex words are packed {real, imag}, two's complement, fixed-point Q1.(HALF−1), where HALF = WIDTH/2.
- Two-stage pipeline with a valid qualifier: latency 2 cycles, throughput 1 butterfly per cycle.

Parameters:
- WIDTH, 36, packed complex word width; must be even. HALF = WIDTH/2 = 18 bits per component, Q1.17, representable range [−1.0, 1.0−2^−17].

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  A, B and W are valid this cycle.
- A  input  WIDTH  complex operand; bits [WIDTH−1:HALF] = real, [HALF−1:0] = imag.
- B  input  WIDTH  complex operand, same packing.
- W  input  WIDTH  twiddle factor, same packing (e.g. W16_0 = {0x1FFFF, 0}, W16_4 = {0, −131072}).
- ApWB  output  WIDTH  A + W·B, packed.
- AnWB  output  WIDTH  A − W·B, packed.
- out_valid  output  1  ApWB and AnWB hold a new result.

Behaviour:
- Reset (reset=0, asynchronous):
  - All pipeline registers, ApWB, AnWB and out_valid clear to 0 immediately.
  - First capture happens on the first rising edge with reset=1.
- Stage 1, on a rising edge with in_valid=1:
  - Register the four signed products Wr·Br, Wi·Bi, Wr·Bi, Wi·Br, each full precision at 2·HALF bits.
  - Register A alongside the products.
- Stage 1 valid bit v1 <= in_valid every cycle. Product and A registers hold their value when in_valid=0.
- Stage 2 arithmetic:
  - WBr = (Wr·Br − Wi·Bi) >>> (HALF−1).
  - WBi = (Wr·Bi + Wi·Br) >>> (HALF−1).
  - The shift is an arithmetic shift that truncates toward −∞ (no rounding).
  - WBr and WBi are kept HALF+2 bits wide, unsaturated.
  - Sums: Ar+WBr, Ai+WBi, Ar−WBr, Ai−WBi, each computed at HALF+3 bits.
- Saturation:
  - Each component saturates independently to [−2^(HALF−1), 2^(HALF−1)−1], i.e. [−131072, 131071].
  - Saturation is applied only at the final sum. The intermediate W·B is not saturated, so (−1)·(−1) is handled correctly.
- Stage 2 register: when v1=1, ApWB and AnWB load their results. out_valid <= v1 every cycle. Outputs hold their last value when v1=0.
- Timing: a result for the inputs presented at edge n appears at edge n+2 with out_valid=1.
  - Back-to-back valid inputs produce back-to-back valid outputs.
  - Bubbles in in_valid propagate as out_valid=0 two cycles later.
- Reset mid-operation: in-flight data is discarded. out_valid stays 0 until two edges after the next in_valid.
- Real and imaginary paths are strictly independent except through the complex multiply. There is no cross-component carry.
- No overflow flag; saturation is silent.

Test Plan:
- Reset: assert reset=0 mid-stream → ApWB=0, AnWB=0, out_valid=0 immediately and asynchronously. After release, the first valid input gives out_valid=1 exactly 2 edges later.
- Unit twiddle:
  - Stimulus: A={65536,0}, B={32768,0}, W={131071,0}.
  - Expected: WBr=32767 (truncated), so ApWB={98303,0}, AnWB={32769,0}.
- −j twiddle:
  - Stimulus: A={65536,0}, B={32768,0}, W={0,−131072}.
  - Expected: WB={0,−32768}, so ApWB={65536,−32768}, AnWB={65536,32768}.
- Positive saturation:
  - Stimulus: A={131071,0}, B={131071,0}, W={131071,0}.
  - Expected: WBr=131070, so ApWB={131071,0} (saturated), AnWB={1,0}.
- Negative saturation and −1·−1:
  - Stimulus: A={−131072,0}, B={−131072,0}, W={−131072,0}.
  - Expected: WBr=131072 (unsaturated), so ApWB={0,0} and AnWB={−131072,0} (saturated).
- Throughput: drive 8 consecutive valid butterflies, then a 1-cycle bubble, then 2 more → 8 consecutive out_valid, one low cycle, 2 more. Each output matches a software model bit-exactly.

Source files
------------

// File: rtl/butterfly_unit.sv
// Radix-2 DIT butterfly: ApWB = A + W*B, AnWB = A - W*B on packed {real, imag}
// Q1.(HALF-1) words, two-stage pipeline (products, then sum/saturate).
module butterfly_unit #(
   parameter int WIDTH = 36
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] W,
   output logic [WIDTH-1:0] ApWB,
   output logic [WIDTH-1:0] AnWB,
   output logic             out_valid
);

   localparam int HALF = WIDTH / 2;
   localparam int PW   = 2 * HALF;

   logic signed [HALF-1:0] wr, wi, br, bi;
   logic signed [PW-1:0]   p_rr_next, p_ii_next, p_ri_next, p_ir_next;
   logic signed [PW-1:0]   p_rr_reg, p_ii_reg, p_ri_reg, p_ir_reg;
   logic [WIDTH-1:0]       a_reg;
   logic                   v1_reg;

   assign wr = W[WIDTH-1:HALF];
   assign wi = W[HALF-1:0];
   assign br = B[WIDTH-1:HALF];
   assign bi = B[HALF-1:0];

   assign p_rr_next = PW'(wr) * PW'(br);
   assign p_ii_next = PW'(wi) * PW'(bi);
   assign p_ri_next = PW'(wr) * PW'(bi);
   assign p_ir_next = PW'(wi) * PW'(br);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         v1_reg   <= 1'b0;
         a_reg    <= '0;
         p_rr_reg <= '0;
         p_ii_reg <= '0;
         p_ri_reg <= '0;
         p_ir_reg <= '0;
      end else begin
         v1_reg <= in_valid;
         if (in_valid) begin
            a_reg    <= A;
            p_rr_reg <= p_rr_next;
            p_ii_reg <= p_ii_next;
            p_ri_reg <= p_ri_next;
            p_ir_reg <= p_ir_next;
         end
      end
   end

   // One extra bit holds the product sum/difference exactly; slicing off the
   // low HALF-1 bits is the floor shift, leaving a HALF+2 bit unsaturated W*B.
   logic signed [PW:0]     wb_re_full, wb_im_full;
   logic signed [HALF+1:0] wb [2];
   logic                   unused_lsbs;

   assign wb_re_full  = (PW+1)'(p_rr_reg) - (PW+1)'(p_ii_reg);
   assign wb_im_full  = (PW+1)'(p_ri_reg) + (PW+1)'(p_ir_reg);
   assign wb[1]       = wb_re_full[PW:HALF-1];
   assign wb[0]       = wb_im_full[PW:HALF-1];
   assign unused_lsbs = ^{wb_re_full[HALF-2:0], wb_im_full[HALF-2:0]};

   // In range only when the top four bits all equal the sign bit.
   function automatic logic [HALF-1:0] sat(input logic signed [HALF+2:0] s);
      if (s[HALF+2:HALF-1] == {4{s[HALF+2]}})
         return s[HALF-1:0];
      else if (s[HALF+2])
         return {1'b1, {(HALF-1){1'b0}}};
      else
         return {1'b0, {(HALF-1){1'b1}}};
   endfunction

   logic [WIDTH-1:0] ap_next, an_next;

   // Index 1 is the real component, index 0 the imaginary one.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_comp
         logic signed [HALF-1:0] a_c;
         logic signed [HALF+2:0] s_p, s_n;

         assign a_c = a_reg[gi*HALF +: HALF];
         assign s_p = (HALF+3)'(a_c) + (HALF+3)'(wb[gi]);
         assign s_n = (HALF+3)'(a_c) - (HALF+3)'(wb[gi]);
         assign ap_next[gi*HALF +: HALF] = sat(s_p);
         assign an_next[gi*HALF +: HALF] = sat(s_n);
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         ApWB      <= '0;
         AnWB      <= '0;
      end else begin
         out_valid <= v1_reg;
         if (v1_reg) begin
            ApWB <= ap_next;
            AnWB <= an_next;
         end
      end
   end

endmodule

// File: tb/tb_butterfly_unit.sv
// Self-checking bench for butterfly_unit: directed table, reset corners and a
// randomized stream compared against an integer-arithmetic reference model.
module tb_butterfly_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [35:0] A = '0, B = '0, W = '0;
   logic [35:0] ApWB, AnWB;
   logic        out_valid;

   int total = 0;
   int bad   = 0;
   logic [35:0] hold_ap = '0, hold_an = '0;

   butterfly_unit #(.WIDTH(36)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid),
      .A(A), .B(B), .W(W),
      .ApWB(ApWB), .AnWB(AnWB), .out_valid(out_valid)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [35:0] a, b, w, ap, an;
   } vec_t;

   function automatic logic [35:0] pk(input int re, input int im);
      return {re[17:0], im[17:0]};
   endfunction

   function automatic int clamp(input longint v);
      if (v > 131071)  return 131071;
      if (v < -131072) return -131072;
      return int'(v);
   endfunction

   // Reference: exact complex product, floor-divide by 2^17, clamp each sum.
   task automatic model(input logic [35:0] a, b, w, output logic [35:0] ap, an);
      longint ar, ai, br, bi, wr, wi, wbr, wbi;
      ar = longint'($signed(a[35:18])); ai = longint'($signed(a[17:0]));
      br = longint'($signed(b[35:18])); bi = longint'($signed(b[17:0]));
      wr = longint'($signed(w[35:18])); wi = longint'($signed(w[17:0]));
      wbr = (wr * br - wi * bi) >>> 17;
      wbi = (wr * bi + wi * br) >>> 17;
      ap = pk(clamp(ar + wbr), clamp(ai + wbi));
      an = pk(clamp(ar - wbr), clamp(ai - wbi));
   endtask

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int rand_comp();
      case ($urandom_range(0, 4))
         0: return -131072;
         1: return 131071;
         default: return int'($urandom_range(0, 262143)) - 131072;
      endcase
   endfunction

   function automatic logic [35:0] rand_word();
      return pk(rand_comp(), rand_comp());
   endfunction

   // One isolated butterfly: checks the empty cycle and the result two edges after driving.
   task automatic run_one(input vec_t v);
      @(negedge clock);
      A = v.a; B = v.b; W = v.w; in_valid = 1'b1;
      @(posedge clock); #1;
      chk({v.name, " bubble"}, {35'd0, out_valid}, 36'd0);
      @(negedge clock);
      in_valid = 1'b0; A = rand_word(); B = rand_word(); W = rand_word();
      @(posedge clock); #1;
      chk({v.name, " valid"}, {35'd0, out_valid}, 36'd1);
      chk({v.name, " ApWB"}, ApWB, v.ap);
      chk({v.name, " AnWB"}, AnWB, v.an);
      $display("vec %s: A=%h B=%h W=%h -> ApWB=%h AnWB=%h", v.name, v.a, v.b, v.w, ApWB, AnWB);
      hold_ap = v.ap; hold_an = v.an;
   endtask

   localparam int N = 160;
   logic [35:0] sa [N], sb [N], sw [N];
   logic        sv [N];

   initial begin
      vec_t tbl [5];
      vec_t rv;
      logic [35:0] eap, ean;
      logic        ev;

      tbl[0] = '{"unit_tw", pk(65536, 0), pk(32768, 0), pk(131071, 0), pk(98303, 0), pk(32769, 0)};
      tbl[1] = '{"neg_j_tw", pk(65536, 0), pk(32768, 0), pk(0, -131072), pk(65536, -32768), pk(65536, 32768)};
      tbl[2] = '{"pos_sat", pk(131071, 0), pk(131071, 0), pk(131071, 0), pk(131071, 0), pk(1, 0)};
      tbl[3] = '{"neg_sat", pk(-131072, 0), pk(-131072, 0), pk(-131072, 0), pk(0, 0), pk(-131072, 0)};
      tbl[4] = '{"imag_sat", pk(0, 131071), pk(0, 131071), pk(131071, 0), pk(0, 131071), pk(0, 1)};

      // Reset state
      #12;
      chk("reset out_valid", {35'd0, out_valid}, 36'd0);
      chk("reset ApWB", ApWB, 36'd0);
      chk("reset AnWB", AnWB, 36'd0);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < 5; i++) run_one(tbl[i]);

      // Mid-stream asynchronous reset discards in-flight work
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         A = pk(100000, -50000); B = rand_word(); W = rand_word(); in_valid = 1'b1;
      end
      @(posedge clock); #2;
      reset = 1'b0; #1;
      chk("async rst out_valid", {35'd0, out_valid}, 36'd0);
      chk("async rst ApWB", ApWB, 36'd0);
      chk("async rst AnWB", AnWB, 36'd0);
      $display("async reset: out_valid=%0d ApWB=%h AnWB=%h", out_valid, ApWB, AnWB);
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      hold_ap = '0; hold_an = '0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clock); #1;
         chk("post rst idle", {35'd0, out_valid}, 36'd0);
         chk("post rst ApWB hold", ApWB, 36'd0);
      end
      rv.name = "post_rst"; rv.a = rand_word(); rv.b = rand_word(); rv.w = rand_word();
      model(rv.a, rv.b, rv.w, rv.ap, rv.an);
      run_one(rv);

      // Stream: 8 valid, 1 bubble, 2 valid, then random occupancy
      for (int i = 0; i < N; i++) begin
         sa[i] = rand_word(); sb[i] = rand_word(); sw[i] = rand_word();
         if (i < 8)        sv[i] = 1'b1;
         else if (i == 8)  sv[i] = 1'b0;
         else if (i < 11)  sv[i] = 1'b1;
         else if (i == 11) sv[i] = 1'b0;
         else              sv[i] = ($urandom_range(0, 3) != 0);
      end
      for (int i = 0; i <= N; i++) begin
         @(negedge clock);
         if (i < N) begin
            A = sa[i]; B = sb[i]; W = sw[i]; in_valid = sv[i];
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clock); #1;
         ev = (i >= 1) ? sv[i-1] : 1'b0;
         if (ev) begin
            model(sa[i-1], sb[i-1], sw[i-1], eap, ean);
            hold_ap = eap; hold_an = ean;
         end
         chk("stream out_valid", {35'd0, out_valid}, {35'd0, ev});
         chk("stream ApWB", ApWB, hold_ap);
         chk("stream AnWB", AnWB, hold_an);
         $display("cycle %0d: in_valid=%0d out_valid=%0d ApWB=%h AnWB=%h", i, in_valid, out_valid, ApWB, AnWB);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
